// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path.
// Contents:
//   FLAG_* : bit positions inside the 4-bit {overflow,cout,negative,zero} flag vector
//   FLAGS_W: width of the flag vector
//   occ_state_e: occupancy encoding of the result stage skid buffer
package alu_pkg;

  localparam int FLAGS_W   = 4;
  localparam int FLAG_OVF  = 3;
  localparam int FLAG_COUT = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/alu_payload_reg.sv
// Enable register with synchronous active-high reset.
// Holds one payload beat ({sum, flags}) of the result stage.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears q to zero
//   en  : load d into q this edge
//   d   : next payload
//   q   : stored payload
module alu_payload_reg #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: payload storage is reset even though its value is don't-care while
  // out_valid=0, because the visible head must read zero straight out of reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the signed adder/subtractor.
// Captures {sum, flags} as one beat and presents it downstream over
// valid/ready through a 2-entry skid buffer (head + skid register), so the
// stage sustains one beat per cycle while in_ready never depends
// combinationally on out_ready.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake (in_ready registered)
//   in_s, in_flags      : adder sum and {overflow,cout,negative,zero}
//   out_valid/out_ready : downstream handshake
//   out_s, out_flags    : head beat, flags passed through bit-exact
//   sticky_clr          : clears sticky_ovf (an accepted overflow beat wins)
//   sticky_ovf          : set by any accepted beat carrying overflow
//   res_count           : wrapping count of beats delivered downstream
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_s,
  input  logic [FLAGS_W-1:0] in_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_s,
  output logic [FLAGS_W-1:0] out_flags,
  input  logic               sticky_clr,
  output logic               sticky_ovf,
  output logic [CNT_W-1:0]   res_count
);

  localparam int PW = WIDTH + FLAGS_W;

  occ_state_e      state, state_nxt;
  logic            accept, deliver;
  logic            head_en, skid_en, head_from_skid;
  logic [PW-1:0]   in_beat, head_d, head_q, skid_q;
  logic            in_ready_q;
  logic            sticky_q;
  logic [CNT_W-1:0] count_q;

  assign in_beat = {in_s, in_flags};
  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid & out_ready;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    head_en        = 1'b0;
    skid_en        = 1'b0;
    head_from_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          head_en   = 1'b1;
        end
      end
      ONE: begin
        if (accept && !deliver) begin
          // Head is stalled; park the new beat behind it.
          state_nxt = TWO;
          skid_en   = 1'b1;
        end else if (!accept && deliver) begin
          state_nxt = EMPTY;
        end else if (accept && deliver) begin
          head_en = 1'b1;
        end
      end
      TWO: begin
        // in_ready is low here, so only a delivery can change occupancy.
        if (deliver) begin
          state_nxt      = ONE;
          head_en        = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign head_d = head_from_skid ? skid_q : in_beat;

  alu_payload_reg #(.W(PW)) u_head (
    .clk (clk),
    .rst (rst),
    .en  (head_en),
    .d   (head_d),
    .q   (head_q)
  );

  alu_payload_reg #(.W(PW)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_beat),
    .q   (skid_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      // Registered copy of "not full" so upstream sees no path from out_ready.
      in_ready_q <= (state_nxt != TWO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (accept && in_flags[FLAG_OVF]) begin
      sticky_q <= 1'b1;
    end else if (sticky_clr) begin
      sticky_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (deliver) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state != EMPTY);
  assign out_s      = head_q[PW-1:FLAGS_W];
  assign out_flags  = head_q[FLAGS_W-1:0];
  assign sticky_ovf = sticky_q;
  assign res_count  = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage (WIDTH=8, CNT_W=4).
// A negedge monitor keeps a scoreboard queue: accepted beats are pushed,
// the head is compared every valid cycle and popped on delivery. The
// monitor also models in_ready/out_valid from queue depth, the sticky
// overflow flag and the wrapping result counter.
module tb_alu_result_stage;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_s;
  logic [3:0]       in_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_s;
  logic [3:0]       out_flags;
  logic             sticky_clr;
  logic             sticky_ovf;
  logic [CNT_W-1:0] res_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH+3:0] sb[$];
  logic [CNT_W-1:0] m_cnt;
  logic             m_sticky;
  logic             mon_en = 1'b0;
  logic             acc, del;

  alu_result_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_s       (in_s),
    .in_flags   (in_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_s      (out_s),
    .out_flags  (out_flags),
    .sticky_clr (sticky_clr),
    .sticky_ovf (sticky_ovf),
    .res_count  (res_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare first against the model of the state after
  // the last edge, then advance the model by what the coming edge will do.
  always @(negedge clk) begin
    if (mon_en) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
      check("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
      check("res_count", 32'(res_count), 32'(m_cnt));
      check("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, m_sticky});
      if (sb.size() != 0) begin
        check("out_s", 32'(out_s), 32'(sb[0][WIDTH+3:4]));
        check("out_flags", 32'(out_flags), 32'(sb[0][3:0]));
      end
    end
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    if (rst) begin
      sb.delete();
      m_cnt    = '0;
      m_sticky = 1'b0;
    end else begin
      if (del && sb.size() != 0) begin
        void'(sb.pop_front());
        m_cnt = m_cnt + 1'b1;
      end
      if (acc) sb.push_back({in_s, in_flags});
      if (acc && in_flags[3]) m_sticky = 1'b1;
      else if (sticky_clr)    m_sticky = 1'b0;
    end
  end

  // Present one beat and hold it until it is accepted (bounded wait).
  task automatic send(input logic [WIDTH-1:0] s, input logic [3:0] f);
    int n = 0;
    in_valid = 1'b1;
    in_s     = s;
    in_flags = f;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_s     = WIDTH'($urandom);
    in_flags = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_s       = '0;
    in_flags   = '0;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // 1: reset in the middle of traffic (stalled beats plus overflow set).
    send(8'hA1, 4'b1000);
    send(8'hA2, 4'b0000);
    do_reset(2);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_sticky", {31'd0, sticky_ovf}, 32'd0);
    check("rst_count", 32'(res_count), 32'd0);
    check("rst_out_s", 32'(out_s), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);

    // 2: streaming, 8 back-to-back beats.
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(WIDTH'(i), 4'b0000);
    drain();
    @(negedge clk);
    check("stream_count", 32'(res_count), 32'd8);

    // 3: backpressure, third beat held off while full.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'h11, 4'b0000);
    send(8'h22, 4'b0100);
    in_valid = 1'b1;
    in_s     = 8'h33;
    in_flags = 4'b0001;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_head", 32'(out_s), 32'h11);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h33, 4'b0001);
    drain();
    @(negedge clk);
    check("bp_count", 32'(res_count), 32'(4'd11));

    // 4: flags pass-through and sticky overflow.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'h80, 4'b1010);
    @(negedge clk);
    check("flag_out", 32'(out_flags), 32'b1010);
    check("flag_sticky", {31'd0, sticky_ovf}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h05, 4'b0000);
    send(8'h00, 4'b0001);
    send(8'hF0, 4'b0110);
    drain();
    @(negedge clk);
    check("flag_sticky_hold", {31'd0, sticky_ovf}, 32'd1);

    // 5: clear racing an overflow beat, then clear alone.
    @(posedge clk);
    #1;
    sticky_clr = 1'b1;
    send(8'h7F, 4'b1100);
    sticky_clr = 1'b0;
    @(negedge clk);
    check("race_sticky", {31'd0, sticky_ovf}, 32'd1);
    @(posedge clk);
    #1;
    sticky_clr = 1'b1;
    @(posedge clk);
    #1;
    sticky_clr = 1'b0;
    @(negedge clk);
    check("clr_sticky", {31'd0, sticky_ovf}, 32'd0);
    drain();

    // 6: counter wrap after 17 deliveries, then a stalled head stays stable.
    do_reset(1);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(WIDTH'($urandom), 4'($urandom_range(0, 7)));
    drain();
    @(negedge clk);
    check("wrap_count", 32'(res_count), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'h5A, 4'b0101);
    repeat (4) begin
      @(negedge clk);
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_s", 32'(out_s), 32'h5A);
      check("stall_flags", 32'(out_flags), 32'b0101);
    end
    drain();
    @(negedge clk);
    check("final_count", 32'(res_count), 32'd2);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
